// File: rtl/mac_tree_seq_if.sv
// mac_tree_seq_if: bundles every non-clock/reset signal of the mac_tree_seq
// sequencer into one interface.
//
// Signal groups:
//   command : start, base_a, base_b, num_chunks, busy
//   sram    : rd_en, rd_addr_a, rd_addr_b, rd_data_a, rd_data_b
//   mac     : mac_a, mac_b, mac_acc_clr, mac_out
//   result  : result, result_valid, result_ready
//   debug   : dbg_state (current sequencer state)
//
// Modports:
//   slave  - the sequencer itself
//   master - the environment around it (command source, SRAMs, mac_tree,
//            result consumer)
interface mac_tree_seq_if #(
  parameter int VEC_LEN = 8,
  parameter int ADDR_W  = 10,
  parameter int LEN_W   = 16
);
  logic                    start;
  logic [ADDR_W-1:0]       base_a;
  logic [ADDR_W-1:0]       base_b;
  logic [LEN_W-1:0]        num_chunks;
  logic                    busy;

  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr_a;
  logic [ADDR_W-1:0]       rd_addr_b;
  logic [32*VEC_LEN-1:0]   rd_data_a;
  logic [32*VEC_LEN-1:0]   rd_data_b;

  logic [32*VEC_LEN-1:0]   mac_a;
  logic [32*VEC_LEN-1:0]   mac_b;
  logic                    mac_acc_clr;
  logic [31:0]             mac_out;

  logic [31:0]             result;
  logic                    result_valid;
  logic                    result_ready;

  logic [2:0]              dbg_state;

  modport slave (
    input  start, base_a, base_b, num_chunks,
    input  rd_data_a, rd_data_b, mac_out, result_ready,
    output busy, rd_en, rd_addr_a, rd_addr_b,
    output mac_a, mac_b, mac_acc_clr,
    output result, result_valid, dbg_state
  );

  modport master (
    output start, base_a, base_b, num_chunks,
    output rd_data_a, rd_data_b, mac_out, result_ready,
    input  busy, rd_en, rd_addr_a, rd_addr_b,
    input  mac_a, mac_b, mac_acc_clr,
    input  result, result_valid, dbg_state
  );
endinterface

// File: rtl/mac_tree_seq.sv
// mac_tree_seq: command-driven sequencer wrapped around mac_tree. For each
// command it fetches num_chunks operand words from two 1-cycle-latency SRAM
// ports, streams them into mac_tree, clears the accumulator beforehand, waits
// out the pipeline drain and returns mac_tree's output as one fp32 result.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - mac_tree_seq_if.slave (command, SRAM, mac_tree, result, debug)
//
// Result handshake: result/result_valid are held stable while result_valid=1
// and result_ready=0; the transfer happens on the rising edge where both are
// 1. result_ready while result_valid=0 is ignored. One command in flight.
module mac_tree_seq #(
  parameter int VEC_LEN   = 8,
  parameter int ADDR_W    = 10,
  parameter int LEN_W     = 16,
  parameter int DRAIN_LAT = 12
) (
  input logic           clk,
  input logic           rst,
  mac_tree_seq_if.slave bus
);
  localparam int DW    = 32 * VEC_LEN;
  localparam int CNT_W = $clog2(DRAIN_LAT + 2);

  typedef enum logic [2:0] {IDLE, CLR, FETCH, DRAIN, HOLD} state_t;

  state_t            state;
  logic              rd_en_r;
  logic [ADDR_W-1:0] rd_addr_a_r;
  logic [ADDR_W-1:0] rd_addr_b_r;
  logic              data_vld;
  logic [DW-1:0]     mac_a_r;
  logic [DW-1:0]     mac_b_r;
  logic              acc_clr_r;
  logic [31:0]       result_r;
  logic              result_valid_r;
  logic [LEN_W-1:0]  remaining;
  logic [CNT_W-1:0]  drain_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rd_en_r        <= 1'b0;
      rd_addr_a_r    <= '0;
      rd_addr_b_r    <= '0;
      data_vld       <= 1'b0;
      mac_a_r        <= '0;
      mac_b_r        <= '0;
      acc_clr_r      <= 1'b0;
      result_r       <= '0;
      result_valid_r <= 1'b0;
      remaining      <= '0;
      drain_cnt      <= '0;
    end else begin
      // SRAM data lands one cycle after rd_en; lanes carry zeros whenever no
      // chunk is in flight so the free-running accumulator adds nothing.
      data_vld  <= rd_en_r;
      mac_a_r   <= data_vld ? bus.rd_data_a : '0;
      mac_b_r   <= data_vld ? bus.rd_data_b : '0;
      acc_clr_r <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            // Address registers double as the latched base addresses.
            rd_addr_a_r <= bus.base_a;
            rd_addr_b_r <= bus.base_b;
            remaining   <= bus.num_chunks;
            acc_clr_r   <= 1'b1;
            state       <= CLR;
          end
        end
        CLR: begin
          if (remaining == '0) begin
            result_r       <= '0;
            result_valid_r <= 1'b1;
            state          <= HOLD;
          end else begin
            rd_en_r <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            rd_en_r   <= 1'b0;
            // +1 covers the SRAM read cycle ahead of the data register.
            drain_cnt <= CNT_W'(DRAIN_LAT + 1);
            state     <= DRAIN;
          end else begin
            rd_addr_a_r <= rd_addr_a_r + ADDR_W'(1);
            rd_addr_b_r <= rd_addr_b_r + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            result_r       <= bus.mac_out;
            result_valid_r <= 1'b1;
            state          <= HOLD;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (bus.result_ready) begin
            result_valid_r <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.rd_en        = rd_en_r;
  assign bus.rd_addr_a    = rd_addr_a_r;
  assign bus.rd_addr_b    = rd_addr_b_r;
  assign bus.mac_a        = mac_a_r;
  assign bus.mac_b        = mac_b_r;
  assign bus.mac_acc_clr  = acc_clr_r;
  assign bus.result       = result_r;
  assign bus.result_valid = result_valid_r;
  assign bus.dbg_state    = state;
endmodule
